// File: rtl/rec_play_ctrl_pkg.sv
// Shared definitions for the recorder: FSM state encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rec_play_ctrl_pkg;

  // Default sizing: 2 s of audio at 48 kHz.
  localparam int ADDR_W_DEF      = 17;
  localparam int MAX_SAMPLES_DEF = 96000;

  // The playback datapath and timer depend on this encoding, so keep it fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/rec_play_ctrl_btn_edge.sv
// Rising-edge detector for one synchronised button level.
// Latency: combinational pulse in the first cycle the level reads 1.
// Backpressure: none; a held button produces exactly one pulse.
//
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high
//   btn   - synchronised button level
//   rise  - one-cycle pulse on a 0->1 transition of btn
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= btn;
    end
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: arbitrates buttons, steps the sample-memory address.
// Latency: strobes are combinational in the sample_tick cycle; state changes one clock after a request.
// Backpressure: none; requests that are not legal in the current state are dropped.
//
// Ports:
//   clk, reset               - system clock, asynchronous active-high reset
//   sample_tick              - one-cycle pulse at the sample rate
//   rec_btn/play_btn/stop_btn - synchronised button levels
//   mem_addr/mem_we/mem_re   - sample-memory port
//   rec_active/play_active   - state decodes
//   done                     - one-cycle pulse when a recording or playback ends
//   rec_len                  - number of samples held from the last recording
module rec_play_ctrl
  import rec_play_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              rec_active,
  output logic              play_active,
  output logic              done,
  output logic [ADDR_W:0]   rec_len
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  logic rec_req;
  logic play_req;
  logic stop_req;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   len_nxt;

  btn_edge u_rec_edge  (.clk(clk), .reset(reset), .btn(rec_btn),  .rise(rec_req));
  btn_edge u_play_edge (.clk(clk), .reset(reset), .btn(play_btn), .rise(play_req));
  btn_edge u_stop_edge (.clk(clk), .reset(reset), .btn(stop_btn), .rise(stop_req));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      rec_len     <= '0;
      rec_active  <= 1'b0;
      play_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      rec_len     <= len_nxt;
      rec_active  <= (state_nxt == REC);
      play_active <= (state_nxt == PLAY);
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    len_nxt   = rec_len;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        // Record has priority over play when both are pressed together.
        if (rec_req) begin
          state_nxt = REC;
          addr_nxt  = '0;
          len_nxt   = '0;
        end else if (play_req && (rec_len != '0)) begin
          state_nxt = PLAY;
          addr_nxt  = '0;
        end
      end
      REC: begin
        // Stop beats a coincident tick, so that tick's sample is not written.
        if (stop_req) begin
          state_nxt = FIN;
        end else if (sample_tick) begin
          mem_we  = 1'b1;
          len_nxt = rec_len + LEN_ONE;
          // The address parks on the last slot rather than wrapping.
          if (addr == ADDR_LAST) begin
            state_nxt = FIN;
          end else begin
            addr_nxt = addr + ADDR_ONE;
          end
        end
      end
      PLAY: begin
        if (stop_req) begin
          state_nxt = FIN;
        end else if (sample_tick) begin
          mem_re = 1'b1;
          // rec_len is nonzero here, so rec_len-1 cannot underflow.
          if ({1'b0, addr} == (rec_len - LEN_ONE)) begin
            state_nxt = FIN;
          end else begin
            addr_nxt = addr + ADDR_ONE;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mem_addr = addr;
  assign done     = (state == FIN);

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Testbench for rec_play_ctrl with MAX_SAMPLES=8, ADDR_W=3.
// A monitor collects write/read addresses and done pulses; each scenario compares against
// sequences computed from the record/playback rules.
module tb_rec_play_ctrl;

  localparam int AW   = 3;
  localparam int MAXS = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic          rec_btn = 1'b0;
  logic          play_btn = 1'b0;
  logic          stop_btn = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic          rec_active;
  logic          play_active;
  logic          done;
  logic [AW:0]   rec_len;

  int checks = 0;
  int errors = 0;
  int wq[$];
  int rq[$];
  int done_cnt = 0;

  always #5 clk = ~clk;

  rec_play_ctrl #(.ADDR_W(AW), .MAX_SAMPLES(MAXS)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .rec_btn(rec_btn), .play_btn(play_btn), .stop_btn(stop_btn),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .rec_active(rec_active), .play_active(play_active), .done(done), .rec_len(rec_len)
  );

  // Mid-cycle monitor: logs memory accesses and checks the strobe rules every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) wq.push_back(int'(mem_addr));
      if (mem_re) rq.push_back(int'(mem_addr));
      if (done) done_cnt++;
      checks++;
      if (((mem_we || mem_re) && !sample_tick) || (mem_we && mem_re)) begin
        errors++;
        $display("FAIL strobe_rule we=%0b re=%0b tick=%0b (required: single strobe only on tick)",
                 mem_we, mem_re, sample_tick);
      end
    end
  end

  function automatic longint q_sig(input int q[$]);
    longint s = 0;
    foreach (q[i]) s = s * 16 + longint'(q[i] + 1);
    return s;
  endfunction

  // Signature of the address sequence 0,1,...,n-1.
  function automatic longint seq_sig(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s = s * 16 + longint'(i + 1);
    return s;
  endfunction

  task automatic drive(input logic t, input logic r, input logic p, input logic s);
    @(posedge clk);
    #1;
    sample_tick = t;
    rec_btn     = r;
    play_btn    = p;
    stop_btn    = s;
  endtask

  task automatic ticks(input int n, input int gap, input logic r, input logic p);
    for (int i = 0; i < n; i++) begin
      for (int j = 1; j < gap; j++) drive(1'b0, r, p, 1'b0);
      drive(1'b1, r, p, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    wq.delete();
    rq.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_re, rec_active, play_active, done, rec_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0d we=%0b re=%0b ra=%0b pa=%0b done=%0b len=%0d required all 0",
               mem_addr, mem_we, mem_re, rec_active, play_active, done, rec_len);
    end
    reset = 1'b0;
  endtask

  task automatic test_record(input int n, input int gap);
    clear_mon();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);   // play press during REC is ignored
    checks++;
    if (rec_active !== 1'b1) begin
      errors++;
      $display("FAIL rec_enter rec_active=%0b required 1", rec_active);
    end
    idle(1);
    ticks(n, gap, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (q_sig(wq) !== seq_sig(n)) begin
      errors++;
      $display("FAIL rec_writes got %0d writes sig=%0h required %0d writes sig=%0h",
               wq.size(), q_sig(wq), n, seq_sig(n));
    end
    checks++;
    if (done_cnt !== 1 || rec_active !== 1'b0) begin
      errors++;
      $display("FAIL rec_done done_cnt=%0d rec_active=%0b required 1 and 0", done_cnt, rec_active);
    end
    checks++;
    if (int'(rec_len) !== n) begin
      errors++;
      $display("FAIL rec_len got %0d required %0d", rec_len, n);
    end
  endtask

  task automatic test_play(input int len, input int gap);
    clear_mon();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);   // rec press during PLAY is ignored
    checks++;
    if (play_active !== 1'b1) begin
      errors++;
      $display("FAIL play_enter play_active=%0b required 1", play_active);
    end
    idle(1);
    ticks(len, gap, 1'b0, 1'b0);
    idle(3);
    ticks(2, gap, 1'b0, 1'b0);        // ticks after the end must not read
    idle(1);
    checks++;
    if (q_sig(rq) !== seq_sig(len) || wq.size() != 0) begin
      errors++;
      $display("FAIL play_reads got %0d reads sig=%0h writes=%0d required %0d reads sig=%0h writes=0",
               rq.size(), q_sig(rq), wq.size(), len, seq_sig(len));
    end
    checks++;
    if (done_cnt !== 1 || play_active !== 1'b0 || int'(rec_len) !== len) begin
      errors++;
      $display("FAIL play_end done_cnt=%0d play_active=%0b rec_len=%0d required 1, 0, %0d",
               done_cnt, play_active, rec_len, len);
    end
  endtask

  task automatic test_play_stop(input int len, input int k);
    clear_mon();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    ticks(k, 3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (q_sig(rq) !== seq_sig(k) || done_cnt !== 1 || int'(rec_len) !== len) begin
      errors++;
      $display("FAIL play_stop reads=%0d sig=%0h done=%0d len=%0d required reads=%0d sig=%0h done=1 len=%0d",
               rq.size(), q_sig(rq), done_cnt, rec_len, k, seq_sig(k), len);
    end
  endtask

  task automatic test_full();
    clear_mon();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10, 4, 1'b1, 1'b0);         // button held: no retrigger after auto-finish
    idle(4);
    checks++;
    if (q_sig(wq) !== seq_sig(MAXS)) begin
      errors++;
      $display("FAIL full_writes got %0d writes sig=%0h required %0d sig=%0h",
               wq.size(), q_sig(wq), MAXS, seq_sig(MAXS));
    end
    checks++;
    if (int'(rec_len) !== MAXS || done_cnt !== 1 || rec_active !== 1'b0) begin
      errors++;
      $display("FAIL full_end rec_len=%0d done=%0d rec_active=%0b required %0d, 1, 0",
               rec_len, done_cnt, rec_active, MAXS);
    end
  endtask

  task automatic test_ignore_and_priority();
    test_reset();
    clear_mon();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (play_active !== 1'b0) begin
      errors++;
      $display("FAIL empty_play play_active=%0b required 0", play_active);
    end
    ticks(2, 4, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (rq.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL empty_play_reads reads=%0d done=%0d required 0 and 0", rq.size(), done_cnt);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (rec_active !== 1'b1 || play_active !== 1'b0) begin
      errors++;
      $display("FAIL rec_priority rec_active=%0b play_active=%0b required 1 and 0", rec_active, play_active);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
  endtask

  task automatic test_stop_tick();
    clear_mon();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    ticks(2, 4, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (q_sig(wq) !== seq_sig(2) || int'(rec_len) !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stop_tick writes=%0d sig=%0h len=%0d done=%0d required 2 sig=%0h len=2 done=1",
               wq.size(), q_sig(wq), rec_len, done_cnt, seq_sig(2));
    end
  endtask

  task automatic test_reset_mid_play();
    test_record(3, 4);
    clear_mon();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    ticks(1, 4, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (play_active !== 1'b1 || int'(mem_addr) !== 1) begin
      errors++;
      $display("FAIL pre_reset play_active=%0b addr=%0d required 1 and 1", play_active, mem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_re, rec_active, play_active, done, rec_len} !== '0) begin
      errors++;
      $display("FAIL async_reset addr=%0d we=%0b re=%0b ra=%0b pa=%0b done=%0b len=%0d required all 0",
               mem_addr, mem_we, mem_re, rec_active, play_active, done, rec_len);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    checks++;
    if (done_cnt !== 0 || q_sig(rq) !== seq_sig(1)) begin
      errors++;
      $display("FAIL reset_no_done done=%0d reads=%0d required 0 and 1", done_cnt, rq.size());
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    ticks(2, 4, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (play_active !== 1'b0 || rq.size() != 1 || rec_len !== '0) begin
      errors++;
      $display("FAIL play_after_reset play_active=%0b reads=%0d len=%0d required 0, 1, 0",
               play_active, rq.size(), rec_len);
    end
  endtask

  initial begin
    int n;
    int gap;
    int k;
    test_reset();
    idle(2);
    test_record(3, 4);
    test_play(3, 4);
    for (int it = 0; it < 4; it++) begin
      n   = $urandom_range(1, MAXS - 1);
      gap = $urandom_range(1, 5);
      test_record(n, gap);
      test_play(n, $urandom_range(1, 5));
      k = $urandom_range(0, n - 1);
      test_play_stop(n, k);
    end
    test_full();
    test_play(MAXS, 2);
    test_ignore_and_priority();
    test_stop_tick();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
